// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the execute-stage branch resolve controller:
// control-transfer kind codes, RV32I branch funct3 codes, FSM state encoding
// and the latched op descriptor.
package branch_resolve_ctrl_pkg;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_REDIR = 2'd2
    } brState_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] funct3;
    } brOp_t;

    function automatic logic isJump(input logic [1:0] kind);
        return (kind == KIND_JAL) || (kind == KIND_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode-side op handshake plus fetch-side redirect handshake and link write.
//   br_*/pc/imm/rs1/rs2 : op from decode (valid/ready)
//   redir_*             : redirect to fetch (valid held until ready)
//   link_*              : one-cycle rd write for JAL/JALR
// slave = the resolve controller, master = decode/fetch/regfile side.
interface branch_resolve_ctrl_if #(parameter int XLEN = 32);
    logic            br_valid;
    logic            br_ready;
    logic [1:0]      br_kind;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;
    logic            link_valid;
    logic [XLEN-1:0] link_data;

    modport slave (
        input  br_valid, br_kind, br_funct3, pc, imm, rs1, rs2, redir_ready,
        output br_ready, redir_valid, redir_pc, link_valid, link_data
    );

    modport master (
        output br_valid, br_kind, br_funct3, pc, imm, rs1, rs2, redir_ready,
        input  br_ready, redir_valid, redir_pc, link_valid, link_data
    );
endinterface

// File: rtl/branch_resolve_ctrl_target.sv
// br_target_calc: pure combinational taken/target decode for one latched op.
//   op        : kind + funct3
//   pc/imm/rs1: target operands
//   cmpEq/Lt  : comparator flags for the latched rs1/rs2
//   taken     : transfer is taken (never set for illegal ops)
//   illegal   : reserved kind or funct3 010/011 on a branch
//   target    : pc+imm, or (rs1+imm) with bit 0 cleared for JALR
module br_target_calc
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  brOp_t           op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            cmpEq,
    input  logic            cmpLt,
    output logic            taken,
    output logic            illegal,
    output logic [XLEN-1:0] target
);
    logic [XLEN-1:0] pcSum;
    logic [XLEN-1:0] jalrSum;

    assign pcSum   = pc + imm;
    assign jalrSum = rs1 + imm;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        target  = pcSum;
        case (op.kind)
            KIND_BRANCH: begin
                case (op.funct3)
                    F3_BEQ:          taken = cmpEq;
                    F3_BNE:          taken = !cmpEq;
                    F3_BLT, F3_BLTU: taken = cmpLt;
                    F3_BGE, F3_BGEU: taken = !cmpLt;
                    default:         illegal = 1'b1;
                endcase
            end
            KIND_JAL:  taken = 1'b1;
            KIND_JALR: begin
                taken  = 1'b1;
                target = jalrSum & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default:   illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences the execute-stage branch comparator for
// BRANCH/JAL/JALR, issues a held redirect plus a one-cycle IF/ID flush
// (fetch predicts not-taken), writes the link for jumps and counts taken
// transfers with a saturating counter.
//   clk_i, rst_n_i     : clock, async active-low reset
//   br                 : decode op / redirect / link handshakes (slave side)
//   cmp_*              : external comparator operands, mode and flags
//   flush_i            : upstream kill of the op in flight
//   flush_o            : one-cycle IF/ID kill on the first redirect cycle
//   illegal_o/misalign_o : one-cycle exception pulses after evaluation
//   taken_cnt_o        : taken transfers since reset, saturating
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    branch_resolve_ctrl_if.slave  br,
    output logic                  cmp_brun_o,
    output logic [XLEN-1:0]       cmp_a_o,
    output logic [XLEN-1:0]       cmp_b_o,
    input  logic                  cmp_eq_i,
    input  logic                  cmp_lt_i,
    input  logic                  flush_i,
    output logic                  flush_o,
    output logic                  illegal_o,
    output logic                  misalign_o,
    output logic [CNT_W-1:0]      taken_cnt_o
);
    brState_t        state, nextState;
    brOp_t           opQ;
    logic [XLEN-1:0] pcQ, immQ, rs1Q, rs2Q;
    logic [XLEN-1:0] redirPcQ, linkDataQ;
    logic            flushPendQ, linkPendQ, illegalQ, misalignQ;
    logic [CNT_W-1:0] cntQ, cntPrevQ;

    logic            accept, evalLive, redirGo;
    logic            calcTaken, calcIllegal;
    logic [XLEN-1:0] calcTarget;

    br_target_calc #(.XLEN(XLEN)) uCalc (
        .op      (opQ),
        .pc      (pcQ),
        .imm     (immQ),
        .rs1     (rs1Q),
        .cmpEq   (cmp_eq_i),
        .cmpLt   (cmp_lt_i),
        .taken   (calcTaken),
        .illegal (calcIllegal),
        .target  (calcTarget)
    );

    assign evalLive = (state == ST_EVAL) && !flush_i;
    // A misaligned taken target raises misalign_o instead of redirecting.
    assign redirGo  = evalLive && calcTaken && !calcTarget[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = br.br_valid && !flush_i;
                if (accept) nextState = ST_EVAL;
            end
            ST_EVAL:  nextState = redirGo ? ST_REDIR : ST_IDLE;
            // flush_i wins over redir_ready: either way the op is finished.
            ST_REDIR: if (flush_i || br.redir_ready) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            opQ        <= '0;
            pcQ        <= '0;
            immQ       <= '0;
            rs1Q       <= '0;
            rs2Q       <= '0;
            redirPcQ   <= '0;
            linkDataQ  <= '0;
            flushPendQ <= 1'b0;
            linkPendQ  <= 1'b0;
            illegalQ   <= 1'b0;
            misalignQ  <= 1'b0;
            cntQ       <= '0;
            cntPrevQ   <= '0;
        end else begin
            if (accept) begin
                opQ  <= '{kind: br.br_kind, funct3: br.br_funct3};
                pcQ  <= br.pc;
                immQ <= br.imm;
                rs1Q <= br.rs1;
                rs2Q <= br.rs2;
            end
            flushPendQ <= redirGo;
            linkPendQ  <= redirGo && isJump(opQ.kind);
            illegalQ   <= evalLive && calcIllegal;
            misalignQ  <= evalLive && calcTaken && calcTarget[1];
            if (redirGo) begin
                redirPcQ  <= calcTarget;
                linkDataQ <= pcQ + XLEN'(4);
                // Count optimistically so the count is visible with the
                // redirect; a later kill rolls it back from cntPrevQ.
                cntPrevQ  <= cntQ;
                if (cntQ != '1) cntQ <= cntQ + CNT_W'(1);
            end else if (state == ST_REDIR && flush_i) begin
                cntQ <= cntPrevQ;
            end
        end
    end

    // Redirect-side outputs are masked by flush_i so a killed op never
    // shows a redirect, flush or link, even on its first REDIR cycle.
    assign br.br_ready    = (state == ST_IDLE);
    assign br.redir_valid = (state == ST_REDIR) && !flush_i;
    assign br.redir_pc    = redirPcQ;
    assign br.link_valid  = linkPendQ && !flush_i;
    assign br.link_data   = linkDataQ;
    assign flush_o        = flushPendQ && !flush_i;
    assign illegal_o      = illegalQ;
    assign misalign_o     = misalignQ;
    assign taken_cnt_o    = cntQ;
    assign cmp_brun_o     = opQ.funct3[1];
    assign cmp_a_o        = rs1Q;
    assign cmp_b_o        = rs2Q;
endmodule
